spi_exe_unit_2: RTL and testbench
=================================

# spi_exe_unit_2

Parametrised SPI-slave arithmetic unit, the successor to the first-generation SPI execution unit. It receives two M-bit operands and an opcode byte serially on MOSI and executes one ALU operation. Result and flags return on MISO within the same chip-select frame, so no second transaction is needed. Adds a width parameter, zero/carry flags, shifts, and frame-abort detection with an error flag.

## Interface
- M, 8: operand/result width in bits (4..32).
- i_sclk  in  1  SPI clock; all logic on rising edge; master drives MOSI and samples MISO on falling edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_cs  in  1  chip select, active low, sampled on i_sclk rising edge.
- i_mosi  in  1  serial data in, MSB first.
- o_miso  out  1  serial data out, MSB first; 0 when not transmitting.
- o_busy  out  1  1 while a frame is in progress (state other than IDLE/DONE).
- o_frame_err  out  1  sticky: last frame was aborted by i_cs rising early.

## Operation
- Frame, counted in i_sclk rising edges with i_cs=0, edge 0 = first:
  - Edges 0..M-1: A.
  - Edges M..2M-1: B.
  - Edges 2M..2M+7: opcode byte; op = byte[7:4], byte[3:0] ignored.
  - Edge 2M+8: execute.
  - Edges 2M+9..3M+11: shift out.
- States:
  - IDLE: on edge with i_cs=0, shift in A MSB, counter=1, go LOAD_A.
  - LOAD_A / LOAD_B / LOAD_OP: shift in; latch field and advance on its last bit.
  - EXEC: compute; load tx register {R, Z, C, S, V} (M+4 bits); go SEND.
  - SEND: shift tx left, zero-fill; after M+3 shifts go DONE.
  - DONE: ignore i_mosi; o_miso=0; i_cs=1 at edge goes IDLE.
- Abort: i_cs=1 at any edge in LOAD_A..SEND goes IDLE, discards partial fields, sets o_frame_err.
  - o_frame_err clears on entry to DONE of the next complete frame.
  - i_cs=1 in IDLE or DONE is not an error.
- ALU (R is M bits, unsigned ops modulo 2^M):
  - 0 ADD: {C,R}=A+B; V = signed overflow.
  - 1 SUB: R=A-B; C = borrow (A<B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise; C=V=0.
  - 5 NOT: R=~A; C=V=0.
  - 6 SHL: R=A<<B[$clog2(M)-1:0]; C = last bit shifted out, 0 if shift amount 0; V=0.
  - 7 SHR: logical shift, same shift-amount and carry rule as SHL; V=0.
  - 8..15 reserved: R=0, C=V=0.
  - For every op: Z=(R==0), S=R[M-1].
- Operand registers hold values until overwritten by the next completed field.

## Timing
- Reset (async, any state, including mid-frame): state IDLE, counters, A, B, op, and tx cleared; o_miso=0, o_busy=0, o_frame_err=0.
- o_busy goes 1 after edge 0; goes 0 on entry to DONE or IDLE.
- o_miso:
  - After edge 2M+8: R[M-1].
  - After edge 2M+8+k: bit k of {R, Z, C, S, V}, for k=0..M+3.
  - After edge 3M+12 (entry to DONE): 0.
- Master samples the k-th response bit on the falling edge following edge 2M+8+k.
- Latency from last opcode bit to first response bit: one edge.
- Minimum frame: 3M+13 edges with i_cs=0, then one edge with i_cs=1 to return to IDLE. Back-to-back frames need that cs-high edge.
- An i_cs low edge arriving in DONE does not start a new frame.

## Test plan
- M=8, A=0x7F, B=0x01, op byte 0x00 (ADD) -> response 0x80, flags Z=0 C=0 S=1 V=1 (bits 1000_0000_0011); o_busy high edges 0..35.
- M=8, A=0x03, B=0x05, op 0x10 (SUB) -> R=0xFE, Z=0 C=1 S=1 V=0; op 0x20 with A=0xF0, B=0x0F (AND) -> R=0x00, Z=1 C=0 S=0 V=0.
- M=8, A=0x81, B=0x09, op 0x60 (SHL, amount 1) -> R=0x02, C=1; op 0x90 (reserved) -> R=0, Z=1 C=0 S=0 V=0.
- Abort: raise i_cs at edge 10 -> IDLE, o_frame_err=1, o_miso=0. Then a full ADD frame with A=0x01, B=0x01 -> R=0x02 and o_frame_err back to 0 at DONE.
- Assert i_rst low mid-SEND -> o_miso, o_busy, o_frame_err all 0 immediately. Next frame with A=0x05, B=0x03, op 0x40 (XOR) -> R=0x06.
- M=16, A=0xFFFF, B=0x0001, ADD -> R=0x0000, Z=1 C=1 S=0 V=0; o_miso first valid after edge 40, DONE after edge 60.

Source files
------------

// File: rtl/spi_exe_unit_2.sv
// spi_exe_unit_2
// SPI-slave arithmetic unit. One chip-select frame carries operand A (M bits),
// operand B (M bits) and an opcode byte on MOSI, MSB first. The unit executes
// one ALU operation and returns {R, Z, C, S, V} on MISO in the same frame.
// Raising chip select before the frame completes aborts it and sets a sticky
// frame-error flag, which clears when the next complete frame finishes.
//
// Ports:
//   i_sclk       SPI clock, all logic on the rising edge
//   i_rst        asynchronous reset, active low
//   i_cs         chip select, active low, sampled on i_sclk rising edge
//   i_mosi       serial data in, MSB first
//   o_miso       serial data out, MSB first, 0 when not transmitting
//   o_busy       1 while a frame is in progress (not IDLE/DONE)
//   o_frame_err  sticky: the last frame was aborted by i_cs rising early
module spi_exe_unit_2 #(
  parameter int M = 8
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_frame_err
);

  localparam int SW  = (M > 8) ? M : 8;  // input shifter also holds the opcode byte
  localparam int TW  = M + 4;
  localparam int CW  = $clog2(M + 5);
  localparam int SAW = $clog2(M);

  localparam logic [CW-1:0] C_FIELD = CW'(M - 1);
  localparam logic [CW-1:0] C_OP    = CW'(7);
  localparam logic [CW-1:0] C_SEND  = CW'(M + 3);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_EXEC, S_SEND, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_sh, w_sh_nxt, w_sh_in;
  logic [M-1:0]    r_a, w_a_nxt;
  logic [M-1:0]    r_b, w_b_nxt;
  logic [3:0]      r_op, w_op_nxt;
  logic [TW-1:0]   r_tx, w_tx_nxt;
  logic            r_err, w_err_nxt;
  logic            r_miso, r_busy;

  logic [M:0]      w_add, w_sub, w_shl, w_shr;
  logic [SAW-1:0]  w_sa;
  logic [M-1:0]    w_res;
  logic            w_c, w_v;

  assign w_sh_in = {r_sh[SW-2:0], i_mosi};
  assign w_sa    = r_b[SAW-1:0];
  assign w_add   = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub   = {1'b0, r_a} - {1'b0, r_b};  // top bit is the borrow
  // Extra bit catches the last bit shifted out; it is 0 for a zero shift.
  assign w_shl   = {1'b0, r_a} << w_sa;
  assign w_shr   = {r_a, 1'b0} >> w_sa;

  // ALU: result and carry/overflow from the latched operands and opcode.
  always_comb begin
    w_res = {M{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      4'd0: begin
        w_res = w_add[M-1:0];
        w_c   = w_add[M];
        w_v   = (r_a[M-1] == r_b[M-1]) && (w_add[M-1] != r_a[M-1]);
      end
      4'd1: begin
        w_res = w_sub[M-1:0];
        w_c   = w_sub[M];
        w_v   = (r_a[M-1] != r_b[M-1]) && (w_sub[M-1] != r_a[M-1]);
      end
      4'd2: w_res = r_a & r_b;
      4'd3: w_res = r_a | r_b;
      4'd4: w_res = r_a ^ r_b;
      4'd5: w_res = ~r_a;
      4'd6: begin
        w_res = w_shl[M-1:0];
        w_c   = w_shl[M];
      end
      4'd7: begin
        w_res = w_shr[M:1];
        w_c   = w_shr[0];
      end
      default: w_res = {M{1'b0}};
    endcase
  end

  // Next-state logic: frame sequencing, field capture, response shifting, abort.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_tx_nxt    = r_tx;
    w_err_nxt   = r_err;
    if (i_cs && (r_state != S_IDLE) && (r_state != S_DONE)) begin
      // Early chip-select release: drop partial fields, keep completed operands.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = {CW{1'b0}};
      w_sh_nxt    = {SW{1'b0}};
      w_tx_nxt    = {TW{1'b0}};
      w_err_nxt   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_cs) begin
            w_sh_nxt    = w_sh_in;
            w_cnt_nxt   = C_ONE;
            w_state_nxt = S_LOAD_A;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_LOAD_A: begin
          w_sh_nxt = w_sh_in;
          if (r_cnt == C_FIELD) begin
            w_a_nxt     = w_sh_in[M-1:0];
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = S_LOAD_B;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_LOAD_B: begin
          w_sh_nxt = w_sh_in;
          if (r_cnt == C_FIELD) begin
            w_b_nxt     = w_sh_in[M-1:0];
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = S_LOAD_OP;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_LOAD_OP: begin
          w_sh_nxt = w_sh_in;
          if (r_cnt == C_OP) begin
            w_op_nxt    = w_sh_in[7:4];  // low nibble of the opcode byte is ignored
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = S_EXEC;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_EXEC: begin
          w_tx_nxt    = {w_res, (w_res == {M{1'b0}}), w_c, w_res[M-1], w_v};
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_SEND;
        end
        S_SEND: begin
          // M+3 shifts expose the remaining bits; the following edge ends the frame.
          if (r_cnt == C_SEND) begin
            w_tx_nxt    = {TW{1'b0}};
            w_cnt_nxt   = {CW{1'b0}};
            w_err_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_tx_nxt  = {r_tx[TW-2:0], 1'b0};
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        S_DONE: begin
          if (i_cs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; outputs registered from next-state values.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_sh    <= {SW{1'b0}};
      r_a     <= {M{1'b0}};
      r_b     <= {M{1'b0}};
      r_op    <= 4'd0;
      r_tx    <= {TW{1'b0}};
      r_err   <= 1'b0;
      r_miso  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_tx    <= w_tx_nxt;
      r_err   <= w_err_nxt;
      r_miso  <= (w_state_nxt == S_SEND) ? w_tx_nxt[TW-1] : 1'b0;
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end
  end

  assign o_miso      = r_miso;
  assign o_busy      = r_busy;
  assign o_frame_err = r_err;

endmodule

// File: tb/tb_spi_exe_unit_2.sv
// Self-checking bench for spi_exe_unit_2: one M=8 and one M=16 instance share
// clock, reset and MOSI, each with its own chip select. A frame-level model
// predicts MISO/busy/error after every rising edge; a compare process checks
// them on each falling edge and also collects the response bits for literal
// checks of the directed cases.
module tb_spi_exe_unit_2;

  logic sclk = 1'b0;
  logic rst_n;
  logic mosi;
  logic cs   [2];
  logic miso [2];
  logic busy [2];
  logic ferr [2];

  int mw [2] = '{8, 16};

  logic exp_miso [2];
  logic exp_busy [2];
  logic exp_err  [2];
  logic exp_cap  [2];
  logic model_err [2];
  logic [63:0] cap [2];
  bit   chk_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sclk = ~sclk;

  spi_exe_unit_2 #(.M(8)) dut8 (
    .i_sclk(sclk), .i_rst(rst_n), .i_cs(cs[0]), .i_mosi(mosi),
    .o_miso(miso[0]), .o_busy(busy[0]), .o_frame_err(ferr[0])
  );

  spi_exe_unit_2 #(.M(16)) dut16 (
    .i_sclk(sclk), .i_rst(rst_n), .i_cs(cs[1]), .i_mosi(mosi),
    .o_miso(miso[1]), .o_busy(busy[1]), .o_frame_err(ferr[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Response {R,Z,C,S,V} from plain integer arithmetic.
  function automatic logic [63:0] model_resp(input int m, input longint a, input longint b, input int op);
    longint full, half, msk, r, c, v, sa, sb, n, p;
    full = longint'(1) << m;
    half = full / 2;
    msk  = full - 1;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    p = 1;
    while (p < m) p = p * 2;
    n = b % p;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin r = (a + b) & msk; c = (a + b) >= full;
               v = ((sa + sb) >= half) || ((sa + sb) < -half); end
      1: begin r = (a - b) & msk; c = a < b;
               v = ((sa - sb) >= half) || ((sa - sb) < -half); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & msk;
      6: begin r = (a << n) & msk; c = (n == 0 || n > m) ? 0 : (a >> (m - n)) & 1; end
      7: begin r = a >> n; c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
      default: r = 0;
    endcase
    return 64'((r << 4) | (longint'(r == 0) << 3) | (c << 2) | (((r >> (m - 1)) & 1) << 1) | v);
  endfunction

  task automatic set_exp(input int sel, input logic m_o, input logic b_o, input logic e_o, input logic cp);
    exp_miso[sel] = m_o;
    exp_busy[sel] = b_o;
    exp_err[sel]  = e_o;
    exp_cap[sel]  = cp;
  endtask

  // Every falling edge: compare both instances against the model.
  always @(negedge sclk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("miso[M=%0d]", mw[i]), 64'(miso[i]), 64'(exp_miso[i]));
        check($sformatf("busy[M=%0d]", mw[i]), 64'(busy[i]), 64'(exp_busy[i]));
        check($sformatf("frame_err[M=%0d]", mw[i]), 64'(ferr[i]), 64'(exp_err[i]));
        if (exp_cap[i]) cap[i] = {cap[i][62:0], miso[i]};
      end
    end
  end

  // Drive one frame. abort_at: edge with cs raised (-1 none);
  // stop_at: return before that edge leaving cs low (-1 none).
  task automatic run_frame(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] opb, input int abort_at, input int stop_at,
                           input logic [63:0] lit, input bit use_lit);
    int m, total, k;
    logic [63:0] resp;
    logic mo;
    m     = mw[sel];
    total = 3 * m + 13;
    resp  = model_resp(m, longint'(a), longint'(b), int'(opb[7:4]));
    cap[sel] = 64'd0;
    for (int e = 0; e < total; e++) begin
      if (e == stop_at) return;
      @(negedge sclk); #1;
      if (e == abort_at) begin
        cs[sel] = 1'b1;
        mosi = 1'($urandom);
        model_err[sel] = 1'b1;
        set_exp(sel, 1'b0, 1'b0, 1'b1, 1'b0);
        return;
      end
      cs[sel] = 1'b0;
      if (e < m)              mosi = a[m - 1 - e];
      else if (e < 2 * m)     mosi = b[2 * m - 1 - e];
      else if (e < 2 * m + 8) mosi = opb[2 * m + 7 - e];
      else                    mosi = 1'($urandom);
      k  = e - (2 * m + 8);
      mo = (k >= 0 && k <= m + 3) ? resp[m + 3 - k] : 1'b0;
      if (e == 3 * m + 12) model_err[sel] = 1'b0;
      set_exp(sel, mo, (e <= 3 * m + 11), model_err[sel], (k >= 0 && k <= m + 3));
    end
    // Chip-select low edges in DONE must not start a frame.
    for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
      @(negedge sclk); #1;
      cs[sel] = 1'b0;
      mosi = 1'($urandom);
      set_exp(sel, 1'b0, 1'b0, model_err[sel], 1'b0);
    end
    @(negedge sclk); #1;
    cs[sel] = 1'b1;
    set_exp(sel, 1'b0, 1'b0, model_err[sel], 1'b0);
    @(negedge sclk); #1;
    if (use_lit) check($sformatf("resp[M=%0d]", m), cap[sel], lit);
  endtask

  task automatic do_reset();
    @(negedge sclk); #1;
    rst_n = 1'b0;
    cs[0] = 1'b1;
    cs[1] = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_miso", 64'(miso[i]), 64'd0);
      check("rst_busy", 64'(busy[i]), 64'd0);
      check("rst_err",  64'(ferr[i]), 64'd0);
      model_err[i] = 1'b0;
      set_exp(i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge sclk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int sel, m, ab;
    logic [31:0] ra, rb, msk;
    rst_n  = 1'b0;
    cs[0]  = 1'b1;
    cs[1]  = 1'b1;
    mosi   = 1'b0;
    chk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_err[i] = 1'b0;
      cap[i] = 64'd0;
      set_exp(i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge sclk);
    for (int i = 0; i < 2; i++) begin
      check("reset_miso", 64'(miso[i]), 64'd0);
      check("reset_busy", 64'(busy[i]), 64'd0);
      check("reset_err",  64'(ferr[i]), 64'd0);
    end
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_frame(0, 32'h7F, 32'h01, 8'h00, -1, -1, 64'h803, 1'b1);
    run_frame(0, 32'h03, 32'h05, 8'h10, -1, -1, 64'hFE6, 1'b1);
    run_frame(0, 32'hF0, 32'h0F, 8'h20, -1, -1, 64'h008, 1'b1);
    run_frame(0, 32'h81, 32'h09, 8'h60, -1, -1, 64'h024, 1'b1);
    run_frame(0, 32'h81, 32'h09, 8'h90, -1, -1, 64'h008, 1'b1);
    run_frame(0, 32'hAA, 32'h55, 8'h30, 10, -1, 64'd0, 1'b0);
    @(negedge sclk); #1;
    check("abort_err", 64'(ferr[0]), 64'd1);
    run_frame(0, 32'h01, 32'h01, 8'h00, -1, -1, 64'h020, 1'b1);
    check("err_cleared", 64'(ferr[0]), 64'd0);
    run_frame(0, 32'h7F, 32'h01, 8'h00, -1, 28, 64'd0, 1'b0);
    do_reset();
    run_frame(0, 32'h05, 32'h03, 8'h40, -1, -1, 64'h060, 1'b1);
    run_frame(1, 32'hFFFF, 32'h0001, 8'h00, -1, -1, 64'h0000C, 1'b1);
    run_frame(1, 32'h8000, 32'h8000, 8'h00, -1, -1, 64'h0000D, 1'b1);

    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 1));
      m   = mw[sel];
      msk = (32'd1 << m) - 32'd1;
      ra  = $urandom & msk;
      rb  = $urandom & msk;
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3 * m + 12)) : -1;
      run_frame(sel, ra, rb, 8'($urandom), ab, -1, 64'd0, 1'b0);
    end

    repeat (2) @(negedge sclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
